game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter GRAV_START, default 48, the initial number of frames per gravity step.
REQ-002 SHALL have parameter GRAV_MIN, default 4, the floor on frames per gravity step.
REQ-003 SHALL have parameter ROWS, default 18, the playfield height.
REQ-004 SHALL have port Clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-007 SHALL have port start, input, 1 bit: begins or restarts a game.
REQ-008 SHALL have ports req_left, req_right, req_rot, req_down and req_drop, inputs, 1 bit each: player requests, treated as levels.
REQ-009 SHALL have ports blk_left, blk_right, blk_rot and blk_down, inputs, 1 bit each: a move in that direction would collide.
REQ-010 SHALL have port spawn_blocked, input, 1 bit: the spawn area is occupied; valid during spawn.
REQ-011 SHALL have port row_full, input, ROWS bits: bit i set means grid row i is full; bit ROWS-1 is the bottom row.
REQ-012 SHALL have ports cmd_left, cmd_right, cmd_rot and cmd_down, outputs, 1 bit each: one-cycle move strobes to the piece datapath.
REQ-013 SHALL have ports spawn and lock, outputs, 1 bit each: one-cycle strobes for new piece and piece-into-grid.
REQ-014 SHALL have port clear_stb, output, 1 bit, and port clear_row, output, 5 bits: a one-cycle row delete and its row index.
REQ-015 SHALL have port game_over, output, 1 bit, and port busy, output, 1 bit.
REQ-016 SHALL have port lines, output, 10 bits: the count of cleared lines.

Function
REQ-017 SHALL be an FSM with states IDLE, SPAWN, PLAY, LOCK, SCAN, CLEAR and OVER, plus DROP when HARD_DROP_EN is defined.
REQ-018 SHALL, in IDLE, move to SPAWN on start=1.
REQ-019 SHALL, in SPAWN, assert spawn for one cycle and reload grav_cnt with the current period; if spawn_blocked=1 in that cycle, go to OVER, otherwise go to PLAY.
REQ-020 SHALL, in PLAY, act only on cycles with frame_tick=1 and issue at most one cmd_* strobe per tick.
REQ-021 SHALL, on each tick, decrement grav_cnt; gravity is due when grav_cnt==0 or req_down=1.
REQ-022 SHALL, when gravity is due, ignore all other requests that tick.
REQ-023 SHALL, when gravity is due and blk_down=0, assert cmd_down and reload grav_cnt.
REQ-024 SHALL, when gravity is due and blk_down=1, issue no strobe and go to LOCK.
REQ-025 SHALL, when gravity is not due, use priority req_rot > req_left > req_right.
REQ-026 SHALL suppress both lateral moves when req_left and req_right are both 1.
REQ-027 SHALL suppress any command whose blk_* input is 1.
REQ-028 SHALL, in LOCK, assert lock for one cycle, set scan index to ROWS-1 and go to SCAN.
REQ-029 SHALL, in SCAN, go to CLEAR if row_full[idx]=1; otherwise go to SPAWN if idx==0, else decrement idx.
REQ-030 SHALL, in CLEAR, assert clear_stb with clear_row=idx for one cycle, increment lines (saturating at 1023) and return to SCAN with idx unchanged.
REQ-031 SHALL rely on row_full being updated by the datapath by the cycle after clear_stb.
REQ-032 SHALL compute period = max(GRAV_MIN, GRAV_START - 2*(lines>>3)) in unsigned arithmetic, with no underflow.
REQ-033 SHALL, in OVER, hold game_over=1; on start=1, clear lines, clear game_over and go to SPAWN.
REQ-034 SHALL drive busy=1 in every state except IDLE and OVER.
REQ-035 SHALL ignore start outside IDLE and OVER.

Reset
REQ-036 SHALL, on Reset=1 at the Clk edge, set state to IDLE, all strobes to 0, game_over to 0, lines to 0, grav_cnt to GRAV_START and idx to ROWS-1.
REQ-037 SHALL give Reset priority over all inputs.
REQ-038 SHALL, when reset is asserted mid-CLEAR or mid-DROP, produce no strobe in the cycle after reset.

Configuration
REQ-039 SHALL recognise macro TETRIS_HARD_DROP_EN.
REQ-040 SHALL, when TETRIS_HARD_DROP_EN is defined, enter DROP from PLAY on a tick with req_drop=1, provided gravity is not due.
REQ-041 SHALL, in DROP, assert cmd_down on every cycle with blk_down=0 (frame_tick not required) and go to LOCK on the first cycle with blk_down=1.
REQ-042 SHALL, when TETRIS_HARD_DROP_EN is not defined, keep the req_drop port but ignore it.

Verification
REQ-043 SHALL verify fall-to-lock: start, spawn_blocked=0, no requests, GRAV_START=48 -> spawn pulse; cmd_down on the 48th tick after spawn; blk_down=1 at the next due tick -> lock, then 18 SCAN cycles, then spawn.
REQ-044 SHALL verify a double row clear: row_full bits 17 and 16 set at SCAN, datapath clearing bit 16 after the first clear -> clear_stb with clear_row=17 twice, lines increases from 0 to 2, then spawn.
REQ-045 SHALL verify arbitration: req_rot=1 and req_left=1 with blk_rot=1 -> no strobe; req_left=1 and req_right=1 -> no strobe; req_right alone -> cmd_right on the tick only.
REQ-046 SHALL verify game over and restart: spawn_blocked=1 at spawn -> game_over=1 and busy=0; start -> lines=0, spawn pulse, game_over=0.
REQ-047 SHALL verify speed scaling: force lines=400 -> period=GRAV_MIN=4; reset asserted during CLEAR -> IDLE next cycle, lines=0, no clear_stb.
REQ-048 SHALL verify hard drop with TETRIS_HARD_DROP_EN defined: req_drop on a tick, blk_down rising after 5 cycles -> 5 consecutive cmd_down, then lock.

Source files
------------

// File: rtl/game_sequencer.sv
// Falling-block game control FSM: spawn, gravity/move arbitration, lock, row scan/clear, scoring.
// Optional hard drop (DROP state) is enabled by defining TETRIS_HARD_DROP_EN.
module game_sequencer #(
  parameter int unsigned GRAV_START = 48,
  parameter int unsigned GRAV_MIN   = 4,
  parameter int unsigned ROWS       = 18
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic            start,
  input  logic            req_left,
  input  logic            req_right,
  input  logic            req_rot,
  input  logic            req_down,
  input  logic            req_drop,
  input  logic            blk_left,
  input  logic            blk_right,
  input  logic            blk_rot,
  input  logic            blk_down,
  input  logic            spawn_blocked,
  input  logic [ROWS-1:0] row_full,
  output logic            cmd_left,
  output logic            cmd_right,
  output logic            cmd_rot,
  output logic            cmd_down,
  output logic            spawn,
  output logic            lock,
  output logic            clear_stb,
  output logic [4:0]      clear_row,
  output logic            game_over,
  output logic            busy,
  output logic [9:0]      lines
);

  localparam int unsigned GravMax   = (GRAV_START > GRAV_MIN) ? GRAV_START : GRAV_MIN;
  localparam int unsigned CntW      = $clog2(GravMax + 1);
  localparam logic [4:0]  IdxBottom = 5'(ROWS - 1);
  localparam logic [9:0]  LinesMax  = 10'h3ff;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StPlay,
    StLock,
    StScan,
    StClear,
    StOver
`ifdef TETRIS_HARD_DROP_EN
    ,
    StDrop
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   grav_cnt_q, grav_cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic [9:0]        lines_q, lines_d;
  logic [CntW-1:0]   period;
  logic [31:0]       grav_sub;
  logic              grav_due;

`ifndef TETRIS_HARD_DROP_EN
  logic unused_req_drop;
  assign unused_req_drop = req_drop;
`endif

  // Speed-up of 2 frames per 8 lines, floored at GRAV_MIN without unsigned wrap.
  assign grav_sub = {23'd0, lines_q[9:3], 1'b0};

  always_comb begin
    if (GRAV_START > GRAV_MIN + grav_sub) begin
      period = CntW'(GRAV_START - grav_sub);
    end else begin
      period = CntW'(GRAV_MIN);
    end
  end

  // A count of 1 means this tick's decrement reaches zero.
  assign grav_due = req_down || (grav_cnt_q <= CntW'(1));

  always_comb begin
    state_d    = state_q;
    grav_cnt_d = grav_cnt_q;
    idx_d      = idx_q;
    lines_d    = lines_q;
    cmd_left   = 1'b0;
    cmd_right  = 1'b0;
    cmd_rot    = 1'b0;
    cmd_down   = 1'b0;
    spawn      = 1'b0;
    lock       = 1'b0;
    clear_stb  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSpawn;
        end
      end

      StSpawn: begin
        spawn      = 1'b1;
        grav_cnt_d = period;
        state_d    = spawn_blocked ? StOver : StPlay;
      end

      StPlay: begin
        if (frame_tick) begin
          if (grav_due) begin
            if (blk_down) begin
              state_d = StLock;
            end else begin
              cmd_down   = 1'b1;
              grav_cnt_d = period;
            end
          end else begin
            grav_cnt_d = grav_cnt_q - CntW'(1);
`ifdef TETRIS_HARD_DROP_EN
            if (req_drop) begin
              state_d = StDrop;
            end else
`endif
            if (req_rot) begin
              cmd_rot = !blk_rot;
            end else if (req_left && req_right) begin
              cmd_left  = 1'b0;
              cmd_right = 1'b0;
            end else if (req_left) begin
              cmd_left = !blk_left;
            end else if (req_right) begin
              cmd_right = !blk_right;
            end
          end
        end
      end

      StLock: begin
        lock    = 1'b1;
        idx_d   = IdxBottom;
        state_d = StScan;
      end

      StScan: begin
        if (row_full[idx_q]) begin
          state_d = StClear;
        end else if (idx_q == 5'd0) begin
          state_d = StSpawn;
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end

      // Index is held: rows above shift down into the cleared row.
      StClear: begin
        clear_stb = 1'b1;
        if (lines_q != LinesMax) begin
          lines_d = lines_q + 10'd1;
        end
        state_d = StScan;
      end

      StOver: begin
        if (start) begin
          lines_d = '0;
          state_d = StSpawn;
        end
      end

`ifdef TETRIS_HARD_DROP_EN
      StDrop: begin
        if (blk_down) begin
          state_d = StLock;
        end else begin
          cmd_down = 1'b1;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      grav_cnt_q <= CntW'(GRAV_START);
      idx_q      <= IdxBottom;
      lines_q    <= '0;
    end else begin
      state_q    <= state_d;
      grav_cnt_q <= grav_cnt_d;
      idx_q      <= idx_d;
      lines_q    <= lines_d;
    end
  end

  assign clear_row = idx_q;
  assign lines     = lines_q;
  assign game_over = (state_q == StOver);
  assign busy      = (state_q != StIdle) && (state_q != StOver);

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized self-checking bench for game_sequencer against a rule-level model
// (gravity tick counting, move arbitration, row-collapse datapath, line scoring).
module tb_game_sequencer;

  localparam int GS   = 48;
  localparam int GM   = 4;
  localparam int ROWS = 18;

  localparam logic [6:0] CL = 7'b1000000;
  localparam logic [6:0] CR = 7'b0100000;
  localparam logic [6:0] CO = 7'b0010000;
  localparam logic [6:0] CD = 7'b0001000;
  localparam logic [6:0] SP = 7'b0000100;
  localparam logic [6:0] LK = 7'b0000010;
  localparam logic [6:0] CS = 7'b0000001;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            frame_tick = 1'b0, start = 1'b0;
  logic            req_left = 1'b0, req_right = 1'b0, req_rot = 1'b0;
  logic            req_down = 1'b0, req_drop = 1'b0;
  logic            blk_left = 1'b0, blk_right = 1'b0, blk_rot = 1'b0, blk_down = 1'b0;
  logic            spawn_blocked = 1'b0;
  logic [ROWS-1:0] row_full = '0;
  logic            cmd_left, cmd_right, cmd_rot, cmd_down, spawn, lock, clear_stb;
  logic [4:0]      clear_row;
  logic            game_over, busy;
  logic [9:0]      lines;

  int vectors = 0;
  int miscompares = 0;
  int m_lines = 0;
  int m_ticks = 0;

  always #5 Clk = ~Clk;

  game_sequencer #(.GRAV_START(GS), .GRAV_MIN(GM), .ROWS(ROWS)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .req_left(req_left), .req_right(req_right), .req_rot(req_rot),
    .req_down(req_down), .req_drop(req_drop),
    .blk_left(blk_left), .blk_right(blk_right), .blk_rot(blk_rot), .blk_down(blk_down),
    .spawn_blocked(spawn_blocked), .row_full(row_full),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rot(cmd_rot), .cmd_down(cmd_down),
    .spawn(spawn), .lock(lock), .clear_stb(clear_stb), .clear_row(clear_row),
    .game_over(game_over), .busy(busy), .lines(lines)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {cmd_left, cmd_right, cmd_rot, cmd_down, spawn, lock, clear_stb};
  endfunction

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic int period_of(input int l);
    int p;
    p = GS - 2 * (l / 8);
    return (p < GM) ? GM : p;
  endfunction

  // Datapath behaviour: deleting row r drops every row above it by one.
  function automatic logic [ROWS-1:0] collapse(input logic [ROWS-1:0] f, input int r);
    logic [ROWS-1:0] n;
    n = f;
    for (int i = r; i > 0; i--) n[i] = f[i-1];
    n[0] = 1'b0;
    return n;
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_tick = 0; start = 0;
    req_left = 0; req_right = 0; req_rot = 0; req_down = 0; req_drop = 0;
    blk_left = 0; blk_right = 0; blk_rot = 0; blk_down = 0;
  endtask

  task automatic start_game();
    idle_inputs();
    spawn_blocked = 0;
    start = 1;
    @(negedge Clk);
    check("start_quiet", strobes(), 7'd0);
    check("start_busy", busy, 1'b0);
    next_cycle();
    start = 0;
    @(negedge Clk);
    check("spawn_pulse", strobes(), SP);
    check("spawn_busy", busy, 1'b1);
    check("spawn_over", game_over, 1'b0);
    check("spawn_lines", lines, m_lines);
    m_ticks = 0;
    next_cycle();
  endtask

  task automatic play_cycle(input string tag, input bit tk, input bit rot, input bit l,
                            input bit r, input bit dn, input bit drop, input bit brot,
                            input bit bl, input bit br, input bit bd, output bit locked);
    logic [6:0] exp;
    bit due;
    frame_tick = tk; req_rot = rot; req_left = l; req_right = r; req_down = dn;
    req_drop = drop; blk_rot = brot; blk_left = bl; blk_right = br; blk_down = bd;
    exp = '0;
    locked = 0;
    if (tk) begin
      due = dn || (m_ticks + 1 >= period_of(m_lines));
      if (due) begin
        if (bd) locked = 1;
        else begin
          exp = CD;
          m_ticks = 0;
        end
      end else begin
        m_ticks++;
        if (rot) exp = brot ? 7'd0 : CO;
        else if (l && r) exp = 7'd0;
        else if (l) exp = bl ? 7'd0 : CL;
        else if (r) exp = br ? 7'd0 : CR;
      end
    end
    @(negedge Clk);
    check(tag, strobes(), exp);
    next_cycle();
  endtask

  task automatic finish_piece(input logic [ROWS-1:0] full, input bit blocked);
    int expq[$];
    int gotq[$];
    logic [ROWS-1:0] f;
    int n;
    bit done, cs;
    int cr;
    idle_inputs();
    row_full = full;
    spawn_blocked = blocked;
    f = full;
    for (int i = ROWS - 1; i >= 0; i--) begin
      while (f[i]) begin
        expq.push_back(i);
        f = collapse(f, i);
      end
    end
    @(negedge Clk);
    check("lock_pulse", strobes(), LK);
    next_cycle();
    n = 0;
    done = 0;
    while (!done && n < 4 * ROWS + 8) begin
      @(negedge Clk);
      if (spawn) done = 1;
      else begin
        n++;
        cs = clear_stb;
        cr = int'(clear_row);
        check("scan_quiet", strobes() & ~CS, 7'd0);
        if (cs) gotq.push_back(cr);
        next_cycle();
        if (cs) row_full = collapse(row_full, cr);
      end
    end
    check("clr_done", done, 1'b1);
    check("clr_count", gotq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      check("clr_row", (i < gotq.size()) ? gotq[i] : -1, expq[i]);
    end
    check("scan_len", n, ROWS + 2 * expq.size());
    m_lines = sat(m_lines + expq.size());
    check("lines", lines, m_lines);
    check("respawn", strobes(), SP);
    m_ticks = 0;
    next_cycle();
  endtask

  task automatic ramp_piece(input int needed, input bit reset_after);
    int cnt, n, budget;
    bit done;
    idle_inputs();
    row_full = '0;
    row_full[ROWS-1] = 1'b1;
    @(negedge Clk);
    check("ramp_lock", strobes(), LK);
    next_cycle();
    cnt = 0; n = 0; done = 0;
    budget = 2 * needed + 4 * ROWS + 8;
    while (!done && n < budget) begin
      @(negedge Clk);
      if (spawn) done = 1;
      else begin
        n++;
        if (clear_stb) cnt++;
        if (clear_stb && cnt == needed) begin
          if (reset_after) begin
            next_cycle();
            next_cycle();
            Reset = 1;
            @(negedge Clk);
            check("rst_in_clear", clear_stb, 1'b1);
            check("sat_lines", lines, sat(m_lines + needed));
            next_cycle();
            Reset = 0;
            @(negedge Clk);
            check("rst_strobes", strobes(), 7'd0);
            check("rst_lines", lines, 10'd0);
            check("rst_busy", busy, 1'b0);
            check("rst_over", game_over, 1'b0);
            m_lines = 0;
            row_full = '0;
            next_cycle();
            return;
          end
          next_cycle();
          row_full = '0;
        end else begin
          next_cycle();
        end
      end
    end
    check("ramp_done", done, 1'b1);
    m_lines = sat(m_lines + needed);
    check("ramp_lines", lines, m_lines);
    check("ramp_spawn", strobes(), SP);
    m_ticks = 0;
    next_cycle();
  endtask

  task automatic force_lock();
    bit locked;
    play_cycle("lock_tick", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, locked);
  endtask

  task automatic random_play(input int cycles);
    bit locked, drop;
    for (int c = 0; c < cycles; c++) begin
`ifdef TETRIS_HARD_DROP_EN
      drop = 0;
`else
      drop = 1'($urandom_range(0, 1));
`endif
      start = 1'($urandom_range(0, 1));
      play_cycle("rand_play", $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, drop, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, locked);
      if (locked) finish_piece(ROWS'($urandom & $urandom), 0);
    end
    start = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit locked;
    idle_inputs();
    Reset = 1;
    next_cycle();
    next_cycle();
    Reset = 0;
    @(negedge Clk);
    check("reset_strobes", strobes(), 7'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_over", game_over, 1'b0);
    check("reset_lines", lines, 10'd0);
    next_cycle();

    // Fall to lock: down on tick 48, blocked at tick 96.
    start_game();
    for (int k = 1; k <= 2 * GS; k++) begin
      play_cycle("fall", 1, 0, 0, 0, 0, 0, 0, 0, 0, (k == 2 * GS), locked);
      if (!locked) play_cycle("fall_gap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, locked);
    end
    finish_piece('0, 0);

    // Arbitration.
    play_cycle("rot_blocked", 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, locked);
    play_cycle("both_lateral", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, locked);
    play_cycle("right_no_tick", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, locked);
    play_cycle("right_tick", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, locked);
    play_cycle("left_blocked", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, locked);
    play_cycle("rot_over_left", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, locked);

    // Double row clear at the bottom.
    force_lock();
    finish_piece(ROWS'(3) << (ROWS - 2), 0);

    random_play(400);

    // Game over and restart.
    force_lock();
    finish_piece('0, 1);
    spawn_blocked = 0;
    @(negedge Clk);
    check("over_flag", game_over, 1'b1);
    check("over_busy", busy, 1'b0);
    check("over_quiet", strobes(), 7'd0);
    next_cycle();
    m_lines = 0;
    start_game();

`ifdef TETRIS_HARD_DROP_EN
    idle_inputs();
    frame_tick = 1;
    req_drop = 1;
    @(negedge Clk);
    check("drop_enter", strobes(), 7'd0);
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("drop_down", strobes(), CD);
      next_cycle();
    end
    blk_down = 1;
    @(negedge Clk);
    check("drop_stop", strobes(), 7'd0);
    next_cycle();
    finish_piece('0, 0);
`else
    play_cycle("drop_ignored", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, locked);
`endif

    // Speed scaling at 400 lines, then saturation and reset inside CLEAR.
    force_lock();
    ramp_piece(400, 0);
    for (int k = 0; k < 2 * GM; k++) begin
      play_cycle("fast_grav", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, locked);
    end
    force_lock();
    ramp_piece(700, 1);

    start_game();
    random_play(60);

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
